// File: rtl/ldpc_llr_loader.sv
// LDPC decoder front end: maps the QBER estimate to a channel LLR magnitude and
// writes one signed initial LLR per received key bit into the decoder LLR memory.
module ldpc_llr_loader #(
  parameter int N        = 1023,
  parameter int WIDTH    = 16,
  parameter int QW       = 16,
  parameter int QIDX     = 8,
  parameter int AW       = $clog2(N),
  parameter bit USE_RAMP = 1'b1,
  parameter logic [(2**QIDX)*(WIDTH-1)-1:0] LUT_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [QW-1:0]    i_qber,
  input  logic             i_bit_in,
  input  logic             i_bit_valid,
  output logic             o_bit_ready,
  output logic             o_llr_we,
  output logic [AW-1:0]    o_llr_addr,
  output logic [WIDTH-1:0] o_llr_data,
  output logic             o_busy,
  output logic             o_done
);

  localparam int MW      = WIDTH - 1;
  localparam int ENTRIES = 2**QIDX;
  localparam int TW      = ENTRIES * MW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_LOAD   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  // Fallback table: magnitude falls linearly from full scale at QBER=0 to zero at QBER=0.5.
  function automatic logic [TW-1:0] build_ramp();
    logic [TW-1:0] v;
    longint half;
    longint maxm;
    v    = '0;
    half = longint'(ENTRIES / 2);
    maxm = (longint'(1) << MW) - 1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (longint'(i) < half)
        v[i*MW +: MW] = MW'(((half - longint'(i)) * maxm) / half);
    end
    return v;
  endfunction

  localparam logic [TW-1:0] LUT_TAB = USE_RAMP ? build_ramp() : LUT_INIT;

  logic [MW-1:0] w_lut [ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_lut
      assign w_lut[gi] = LUT_TAB[gi*MW +: MW];
    end
    if (QW > QIDX) begin : g_qlsb
      logic w_unused_qber;
      assign w_unused_qber = ^i_qber[QW-QIDX-1:0];
    end
  endgenerate

  logic [1:0]       r_state;
  logic [QIDX-1:0]  r_idx;
  logic [MW-1:0]    r_mag;
  logic [AW-1:0]    r_count;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_data;
  logic             r_done;

  logic             w_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] w_pos;
  logic [WIDTH-1:0] w_neg;

  // Ready is a pure state decode so the bit source sees no combinational loop.
  assign w_ready = (r_state == S_LOAD);
  assign w_xfer  = w_ready & i_bit_valid;
  assign w_pos   = {1'b0, r_mag};
  assign w_neg   = WIDTH'(0) - w_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_mag   <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_idx   <= i_qber[QW-1 -: QIDX];
            r_count <= '0;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_mag   <= w_lut[r_idx];
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_we    <= 1'b1;
            r_addr  <= r_count;
            r_data  <= i_bit_in ? w_neg : w_pos;
            r_count <= r_count + AW'(1);
            // The final write and done land together in the DONE cycle.
            if (r_count == LAST_ADDR) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_bit_ready = w_ready;
  assign o_llr_we    = r_we;
  assign o_llr_addr  = r_addr;
  assign o_llr_data  = r_data;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule
